// File: rtl/moving_average_filter_p.sv
// Stereo moving-average filter using external SRAM as a per-channel delay line.
// Power-of-two window, shift gain with saturation, bypass, and flush on reset/window change.
module moving_average_filter_p #(
    parameter int unsigned W            = 16,
    parameter int unsigned LOG2_MAX_LEN = 7,
    parameter int unsigned ADDR_W       = 18,
    parameter int unsigned GAIN_SHIFT   = 1
) (
    input  logic                    BCK,
    input  logic                    RESET_N,
    input  logic                    LRCK,
    input  logic signed [W-1:0]     inL,
    input  logic signed [W-1:0]     inR,
    input  logic signed [W-1:0]     memoryRead,
    input  logic [2:0]              len_log2,
    input  logic                    bypass,
    output logic [ADDR_W-1:0]       addr_out,
    output logic [W-1:0]            data_out,
    output logic                    rwb,
    output logic signed [W-1:0]     outL,
    output logic signed [W-1:0]     outR,
    output logic                    busy,
    output logic                    sat
);
    localparam int unsigned ACC_W   = W + LOG2_MAX_LEN;
    localparam int unsigned EXT_W   = ACC_W + GAIN_SHIFT;
    localparam int unsigned IDX_W   = LOG2_MAX_LEN;
    localparam int unsigned FLUSH_W = LOG2_MAX_LEN + 2;
    localparam int unsigned CNT_W   = 8;

    localparam logic [FLUSH_W-1:0]      FLUSH_LAST = FLUSH_W'((4 << LOG2_MAX_LEN) - 1);
    localparam logic signed [EXT_W-1:0] SAT_HI     = EXT_W'({(W-1){1'b1}});
    localparam logic signed [EXT_W-1:0] SAT_LO     = ~SAT_HI;

    localparam logic [1:0] ST_FLUSH = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    logic [1:0]               state, state_d;
    logic [FLUSH_W-1:0]       fcnt, fcnt_d;
    logic [CNT_W-1:0]         cnt, cnt_d;
    logic                     lrck_prev;
    logic                     ch, ch_d;
    logic [IDX_W-1:0]         idx, idx_d;
    logic signed [ACC_W-1:0]  acc_l, acc_l_d;
    logic signed [ACC_W-1:0]  acc_r, acc_r_d;
    logic [2:0]               len_act, len_act_d;

    logic [ADDR_W-1:0]        addr_d;
    logic [W-1:0]             data_d;
    logic                     rwb_d;
    logic signed [W-1:0]      outl_d, outr_d;
    logic                     busy_d, sat_d;

    logic                     lrck_edge;
    logic [2:0]               len_req;
    logic [IDX_W-1:0]         idx_mask, idx_inc;
    logic signed [W-1:0]      in_cur;
    logic signed [ACC_W-1:0]  acc_cur, acc_upd, acc_shr;
    logic signed [EXT_W-1:0]  acc_ext;
    logic                     clip_hi, clip_lo;
    logic signed [W-1:0]      filt, out_val;

    // Datapath: window clamp, accumulator update and saturating filter output
    always_comb begin
        lrck_edge = (LRCK != lrck_prev);
        len_req   = (32'(len_log2) > LOG2_MAX_LEN) ? 3'(LOG2_MAX_LEN) : len_log2;
        idx_mask  = IDX_W'((32'd1 << len_act) - 32'd1);
        idx_inc   = (idx + IDX_W'(1)) & idx_mask;
        in_cur    = ch ? inR : inL;
        acc_cur   = ch ? acc_r : acc_l;
        acc_upd   = acc_cur + ACC_W'(in_cur) - ACC_W'(memoryRead);
        acc_shr   = acc_cur >>> len_act;
        acc_ext   = EXT_W'(acc_shr) <<< GAIN_SHIFT;
        clip_hi   = (acc_ext > SAT_HI);
        clip_lo   = (acc_ext < SAT_LO);
        if (clip_hi) begin
            filt = SAT_HI[W-1:0];
        end else if (clip_lo) begin
            filt = SAT_LO[W-1:0];
        end else begin
            filt = acc_ext[W-1:0];
        end
        out_val = bypass ? in_cur : filt;
    end

    // Next-state and output logic
    always_comb begin
        state_d   = state;
        fcnt_d    = fcnt;
        ch_d      = ch;
        idx_d     = idx;
        acc_l_d   = acc_l;
        acc_r_d   = acc_r;
        len_act_d = len_act;
        addr_d    = addr_out;
        data_d    = data_out;
        rwb_d     = rwb;
        outl_d    = outL;
        outr_d    = outR;
        busy_d    = busy;
        sat_d     = sat;
        cnt_d     = lrck_edge ? CNT_W'(1) : ((cnt == '1) ? cnt : cnt + CNT_W'(1));

        case (state)
            ST_FLUSH: begin
                busy_d = 1'b1;
                outl_d = '0;
                outr_d = '0;
                if (!fcnt[0]) begin
                    addr_d = ADDR_W'(fcnt[FLUSH_W-1:1]);
                    data_d = '0;
                    rwb_d  = 1'b0;
                end else begin
                    rwb_d  = 1'b1;
                end
                fcnt_d = fcnt + FLUSH_W'(1);
                if (fcnt == FLUSH_LAST) begin
                    fcnt_d    = '0;
                    acc_l_d   = '0;
                    acc_r_d   = '0;
                    idx_d     = '0;
                    len_act_d = len_req;
                    busy_d    = 1'b0;
                    state_d   = ST_WAIT;
                end
            end
            ST_WAIT: begin
                rwb_d = 1'b1;
                if (lrck_edge) begin
                    state_d = ST_RUN;
                    ch_d    = ~LRCK;
                    addr_d  = ADDR_W'({~LRCK, idx});
                end
            end
            ST_RUN: begin
                if (lrck_edge && (len_req != len_act)) begin
                    // Window change: drop this slot and rebuild the delay line
                    state_d = ST_FLUSH;
                    fcnt_d  = '0;
                    busy_d  = 1'b1;
                    rwb_d   = 1'b1;
                    outl_d  = '0;
                    outr_d  = '0;
                end else begin
                    case (cnt_d)
                        CNT_W'(1): begin
                            ch_d   = ~LRCK;
                            addr_d = ADDR_W'({~LRCK, idx});
                            rwb_d  = 1'b1;
                        end
                        CNT_W'(3): begin
                            if (ch) begin
                                acc_r_d = acc_upd;
                            end else begin
                                acc_l_d = acc_upd;
                            end
                            data_d = in_cur;
                            rwb_d  = 1'b0;
                        end
                        CNT_W'(4): begin
                            rwb_d = 1'b1;
                            if (ch) begin
                                outr_d = out_val;
                            end else begin
                                outl_d = out_val;
                            end
                            if (!bypass && (clip_hi || clip_lo)) begin
                                sat_d = 1'b1;
                            end
                        end
                        CNT_W'(5): begin
                            if (ch) begin
                                idx_d = idx_inc;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                state_d = ST_FLUSH;
                fcnt_d  = '0;
                busy_d  = 1'b1;
                rwb_d   = 1'b1;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge BCK) begin
        if (!RESET_N) begin
            state     <= ST_FLUSH;
            fcnt      <= '0;
            cnt       <= '1;
            lrck_prev <= LRCK;
            ch        <= 1'b0;
            idx       <= '0;
            acc_l     <= '0;
            acc_r     <= '0;
            len_act   <= len_req;
            addr_out  <= '0;
            data_out  <= '0;
            rwb       <= 1'b1;
            outL      <= '0;
            outR      <= '0;
            busy      <= 1'b1;
            sat       <= 1'b0;
        end else begin
            state     <= state_d;
            fcnt      <= fcnt_d;
            cnt       <= cnt_d;
            lrck_prev <= LRCK;
            ch        <= ch_d;
            idx       <= idx_d;
            acc_l     <= acc_l_d;
            acc_r     <= acc_r_d;
            len_act   <= len_act_d;
            addr_out  <= addr_d;
            data_out  <= data_d;
            rwb       <= rwb_d;
            outL      <= outl_d;
            outR      <= outr_d;
            busy      <= busy_d;
            sat       <= sat_d;
        end
    end

endmodule

// File: doc/moving_average_filter_p.md
Name: moving_average_filter_p

Overview:
- Parametrised successor to the single-window stereo moving-average filter in the I2S path.
- Sits between the I2S deserializer (inL/inR) and serializer (outL/outR), and uses the external SRAM as the delay line.
- Adds a runtime-selectable power-of-two window, separate SRAM regions per channel, and a memory flush on reset or window change.
- Also adds shift-based gain with saturation, a bypass mode, and a busy indication.

Parameters:
- W, 16, sample width (signed two's complement).
- LOG2_MAX_LEN, 7, log2 of the maximum window length (128 samples per channel).
- ADDR_W, 18, SRAM address width.
- GAIN_SHIFT, 1, output gain as a left shift (×2).

Ports:
- BCK  input  1  bit clock; all logic on posedge.
- RESET_N  input  1  synchronous, active-low reset.
- LRCK  input  1  word select; high = process L slot, low = process R slot.
- inL  input  W  signed left input sample.
- inR  input  W  signed right input sample.
- memoryRead  input  W  SRAM read data; valid 2 BCK after addr_out is presented with rwb=1.
- len_log2  input  3  requested window = 2^len_log2; clamped to LOG2_MAX_LEN.
- bypass  input  1  1 = outputs carry the raw input sample.
- addr_out  output  ADDR_W  SRAM address = {zeros, ch, idx[LOG2_MAX_LEN-1:0]}; ch=0 for L, 1 for R.
- data_out  output  W  SRAM write data.
- rwb  output  1  1 = read, 0 = write.
- outL  output  W  signed filtered left sample.
- outR  output  W  signed filtered right sample.
- busy  output  1  flush in progress.
- sat  output  1  sticky: some output has saturated since reset.

Behaviour:
- **Reset** (RESET_N=0 at posedge BCK):
  - addr_out=0, data_out=0, rwb=1, outL=outR=0, sat=0, busy=1.
  - Accumulators = 0, idx = 0, LRCK_prev = LRCK, active length latched from len_log2 (clamped).
  - On release, FLUSH starts immediately.
- **States:** FLUSH, WAIT_EDGE, RUN.
- **Slot counter cnt** (8 bit):
  - Set to 1 on the BCK where LRCK != LRCK_prev; otherwise increments, saturating at 255.
  - Each LRCK half-frame is one slot: ch = ~LRCK.
- **RUN slot sequence** (cnt values):
  - 1: addr_out={ch,idx}, rwb=1.
  - 2: hold.
  - 3: old = memoryRead; acc_ch += in_ch − old; data_out = in_ch; rwb=0.
  - 4: rwb=1; out_ch updated from acc_ch (accumulator value after the cnt-3 update).
  - 5: if ch=R, idx = (idx+1) mod 2^len.
  - Further cnt values: idle.
- **Latency:** out_ch changes at cnt 4 of its own slot.
- **Accumulator:** signed, W+LOG2_MAX_LEN bits; exact, never overflows.
- **Filter output:**
  - f = (acc >>> len_log2_active) <<< GAIN_SHIFT, computed at full width.
  - Saturated to [−2^(W−1), 2^(W−1)−1].
  - Clipping sets sat.
- **Bypass:**
  - out_ch = in_ch (no gain) at cnt 4.
  - Accumulator and SRAM updates continue, so deasserting bypass is glitch-free.
  - No flush on bypass change.
- **Window change:**
  - Clamped len_log2 differing from the active value, seen at any LRCK edge in RUN, enters FLUSH on that BCK.
  - That slot is not processed.
- **FLUSH:**
  - busy=1; outL/outR forced to 0.
  - For k = 0 .. 2·2^LOG2_MAX_LEN−1:
    - even cycle: addr_out=k, data_out=0, rwb=0.
    - odd cycle: rwb=1.
  - Then: accumulators=0, idx=0, active length latched, busy=0, go to WAIT_EDGE.
  - Duration: 4·2^LOG2_MAX_LEN BCK (512 at defaults).
  - LRCK edges during FLUSH are ignored.
  - Reset mid-flush restarts the flush from k=0.
- **WAIT_EDGE:** rwb=1; enter RUN at the next LRCK edge, with that edge counting as cnt=1.
- **Short half-frames:** if LRCK toggles before cnt=3, that slot is skipped: no accumulator, SRAM, or output change, and rwb stays 1. Requirement: ≥6 BCK per half-frame.
- **rwb=0 rule:** rwb is 0 for exactly one BCK per write, and never outside cnt 3 (RUN) or even FLUSH cycles.

Test Plan:
- **Reset and flush:**
  - Stimulus: RESET_N low 2 cycles, then high.
  - Required response:
    - During reset: rwb=1, busy=1.
    - After release: 256 zero writes at addr 0..255, busy falls after 512 BCK, outL=outR=0.
- **Step response:**
  - Stimulus: len_log2=2, GAIN_SHIFT=1, inL=1000 constant, inR=0, 32 BCK per half-frame.
  - Required response: outL over successive frames = 500, 1000, 1500, 2000, then holds at 2000; outR stays 0.
- **Channel isolation:**
  - Stimulus: inL=1000, inR=−400, len_log2=2.
  - Required response:
    - L and R addresses differ only in bit 7 (L at 0..3, R at 128..131).
    - Steady state: outL=2000, outR=−800.
- **Saturation:**
  - Stimulus: inL=30000 constant, len_log2=2.
  - Required response: outL reaches 32767, sat=1. Then inR=−30000 → outR reaches −32768.
- **Window change:**
  - Stimulus: switch len_log2 from 2 to 3 mid-stream.
  - Required response: busy for 512 BCK, outputs 0; then with inL=1000, outL ramps by 250 per frame to 2000.
- **Bypass and short slot:**
  - Stimulus: bypass=1, inL=1234.
  - Required response: outL=1234 at cnt 4.
  - Stimulus: a half-frame of only 2 BCK.
  - Required response: no write (rwb stays 1), outputs unchanged.
